// File: rtl/path_lock_arbiter.sv
// path_lock_arbiter
//   Central lock manager for the parallel 2-opt/swap workers. Each worker asks
//   for exclusive ownership of the path window {v1-1, v1, v1+1, v2-1, v2, v2+1}
//   (positions mod 2**IDX_W). At most one non-conflicting request is granted per
//   cycle, picked round-robin. The owner's release pulse frees its window.
//
// Optional feature macro: PATH_LOCK_TIMEOUT_EN
//   When defined, a worker that holds a window for TIMEOUT cycles without
//   releasing it is force-released and its timeout bit pulses.
//   When undefined, timeout is tied to 0 and ownership lasts until release.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req          per-worker request level (ignored while the worker holds a window)
//   v1, v2       packed positions, worker i at [i*IDX_W +: IDX_W]
//   rel          per-worker release pulse (ignored while the worker is idle)
//   grant        one-cycle pulse: window now owned
//   reject       one-cycle pulse: pair invalid (equal or adjacent)
//   busy         worker currently owns a window
//   lock_map     bit p set = position p locked
//   grant_count  grants since reset, wraps
//   timeout      one-cycle pulse on forced release
module path_lock_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*IDX_W-1:0] v1,
    input  logic [NUM_REQ*IDX_W-1:0] v2,
    input  logic [NUM_REQ-1:0]       rel,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       reject,
    output logic [NUM_REQ-1:0]       busy,
    output logic [(1<<IDX_W)-1:0]    lock_map,
    output logic [31:0]              grant_count,
    output logic [NUM_REQ-1:0]       timeout
);

    localparam int PATH_LEN = 1 << IDX_W;
    localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]    IDX_ONE = 1;
    localparam logic [PATH_LEN-1:0] BIT0    = 1;

    logic [NUM_REQ-1:0]                owner_valid_unused;
    logic [NUM_REQ-1:0][PATH_LEN-1:0]  owner_mask_reg;
    logic [NUM_REQ-1:0][PATH_LEN-1:0]  win_mask;
    logic [NUM_REQ-1:0]                invalid;
    logic [NUM_REQ-1:0]                eligible;
    logic [NUM_REQ-1:0]                reject_next;
    logic [NUM_REQ-1:0]                forced;
    logic [NUM_REQ-1:0]                rel_eff;
    logic [NUM_REQ-1:0]                grant_next;
    logic [NUM_REQ-1:0]                busy_next;
    logic [PATH_LEN-1:0]               rel_masks;
    logic [PATH_LEN-1:0]               lock_map_next;
    logic [NUM_REQ-1:0]                grant_reg, reject_reg, busy_reg, timeout_reg;
    logic [PATH_LEN-1:0]               lock_map_reg;
    logic [31:0]                       grant_count_reg;
    logic [PTR_W-1:0]                  rr_ptr_reg, rr_ptr_next;
    logic                              found;
    logic [PTR_W-1:0]                  win_idx;

    assign owner_valid_unused = '0;

    // Per-worker window mask, validity and eligibility. Index arithmetic is
    // done at IDX_W bits so that +-1 wraps around the tour naturally.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_worker
            logic [IDX_W-1:0] a, b, a_m, a_p, b_m, b_p;
            assign a   = v1[gi*IDX_W +: IDX_W];
            assign b   = v2[gi*IDX_W +: IDX_W];
            assign a_m = a - IDX_ONE;
            assign a_p = a + IDX_ONE;
            assign b_m = b - IDX_ONE;
            assign b_p = b + IDX_ONE;
            assign win_mask[gi] = (BIT0 << a_m) | (BIT0 << a) | (BIT0 << a_p)
                                | (BIT0 << b_m) | (BIT0 << b) | (BIT0 << b_p);
            assign invalid[gi]     = (b == a) || (b == a_p) || (b == a_m);
            // Registered lock_map only: a same-cycle release does not help.
            assign eligible[gi]    = req[gi] && !busy_reg[gi] && !invalid[gi]
                                     && ((win_mask[gi] & lock_map_reg) == '0);
            assign reject_next[gi] = req[gi] && !busy_reg[gi] && invalid[gi];
        end
    endgenerate

`ifdef PATH_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [NUM_REQ-1:0][CNT_W-1:0] hold_cnt_reg;

    // Force release on the HELD cycle that brings the count to TIMEOUT; an
    // explicit release in that same cycle wins and suppresses the pulse.
    always_comb begin
        forced = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            forced[i] = busy_reg[i] && !rel[i]
                        && (hold_cnt_reg[i] == CNT_W'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_next[i] || rel_eff[i])
                    hold_cnt_reg[i] <= '0;
                else if (busy_reg[i])
                    hold_cnt_reg[i] <= hold_cnt_reg[i] + 1'b1;
            end
        end
    end
`else
    assign forced = '0;
`endif

    assign rel_eff = (rel & busy_reg) | forced;

    // Round-robin scan starting at rr_ptr; first eligible index wins.
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_next  = '0;
        rr_ptr_next = rr_ptr_reg;
        if (found) begin
            grant_next[win_idx] = 1'b1;
            rr_ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    // Grant and release sets are disjoint: a winner is idle, a releaser is held.
    always_comb begin
        rel_masks = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rel_eff[i])
                rel_masks = rel_masks | owner_mask_reg[i];
        end
        lock_map_next = lock_map_reg & ~rel_masks;
        if (found)
            lock_map_next = lock_map_next | win_mask[win_idx];
        busy_next = (busy_reg & ~rel_eff) | grant_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_mask_reg  <= '0;
            lock_map_reg    <= '0;
            grant_reg       <= '0;
            reject_reg      <= '0;
            busy_reg        <= '0;
            timeout_reg     <= '0;
            grant_count_reg <= '0;
            rr_ptr_reg      <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_next[i])
                    owner_mask_reg[i] <= win_mask[i];
                else if (rel_eff[i])
                    owner_mask_reg[i] <= '0;
            end
            lock_map_reg <= lock_map_next;
            grant_reg    <= grant_next;
            reject_reg   <= reject_next;
            busy_reg     <= busy_next;
            timeout_reg  <= forced;
            rr_ptr_reg   <= rr_ptr_next;
            if (found)
                grant_count_reg <= grant_count_reg + 32'd1;
        end
    end

    assign grant       = grant_reg | owner_valid_unused;
    assign reject      = reject_reg;
    assign busy        = busy_reg;
    assign lock_map    = lock_map_reg;
    assign grant_count = grant_count_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_path_lock_arbiter.sv
module tb_path_lock_arbiter;

`ifdef PATH_LOCK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req, rel;
    logic [29:0] v1, v2;
    logic [4:0]  grant, reject, busy, timeout;
    logic [63:0] lock_map;
    logic [31:0] grant_count;

    int n_cmp = 0;
    int n_bad = 0;

    path_lock_arbiter #(.NUM_REQ(5), .IDX_W(6), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .v1(v1), .v2(v2), .rel(rel),
        .grant(grant), .reject(reject), .busy(busy), .lock_map(lock_map),
        .grant_count(grant_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  req;
        logic [4:0]  rel;
        logic [29:0] v1;
        logic [29:0] v2;
        logic [4:0]  grant;
        logic [4:0]  reject;
        logic [4:0]  busy;
        logic [63:0] lmap;
        int          gc;
    } vec_t;

    function automatic logic [29:0] pk(int a0, int a1, int a2, int a3, int a4);
        return {6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic logic [63:0] bm6(int p0, int p1, int p2, int p3, int p4, int p5);
        logic [63:0] m;
        m = '0;
        m[p0] = 1'b1; m[p1] = 1'b1; m[p2] = 1'b1;
        m[p3] = 1'b1; m[p4] = 1'b1; m[p5] = 1'b1;
        return m;
    endfunction

    function automatic vec_t mk(logic [4:0] rq, logic [4:0] rl, logic [29:0] a, logic [29:0] b,
                                logic [4:0] g, logic [4:0] rj, logic [4:0] bs,
                                logic [63:0] lm, int gc);
        vec_t t;
        t.req = rq; t.rel = rl; t.v1 = a; t.v2 = b;
        t.grant = g; t.reject = rj; t.busy = bs; t.lmap = lm; t.gc = gc;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rel = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        logic [63:0] l0, l1, l3, l4, l5;
        v1 = '0; v2 = '0;
        do_reset();

        chk("reset grant",   64'(grant), 64'd0);
        chk("reset reject",  64'(reject), 64'd0);
        chk("reset busy",    64'(busy), 64'd0);
        chk("reset lock_map", lock_map, 64'd0);
        chk("reset count",   64'(grant_count), 64'd0);
        chk("reset timeout", 64'(timeout), 64'd0);
        $display("reset: grant=%b busy=%b lock_map=%h count=%0d", grant, busy, lock_map, grant_count);

`ifndef PATH_LOCK_TIMEOUT_EN
        l0 = bm6(9, 10, 11, 19, 20, 21);
        l1 = bm6(11, 12, 13, 29, 30, 31);
        l3 = bm6(63, 0, 1, 31, 32, 33);
        l4 = bm6(41, 42, 43, 54, 55, 56);
        l5 = bm6(39, 40, 41, 49, 50, 51);
        // req, rel, v1, v2 -> grant, reject, busy, lock_map, grant_count
        vecs[0]  = mk(5'b00001, 5'b00000, pk(10,12,5,0,42),  pk(20,30,6,32,55),  5'b00001, 5'b00000, 5'b00001, l0, 1);
        vecs[1]  = mk(5'b00010, 5'b00000, pk(10,12,5,0,42),  pk(20,30,6,32,55),  5'b00000, 5'b00000, 5'b00001, l0, 1);
        vecs[2]  = mk(5'b00010, 5'b00001, pk(10,12,5,0,42),  pk(20,30,6,32,55),  5'b00000, 5'b00000, 5'b00000, 64'd0, 1);
        vecs[3]  = mk(5'b00010, 5'b00000, pk(10,12,5,0,42),  pk(20,30,6,32,55),  5'b00010, 5'b00000, 5'b00010, l1, 2);
        vecs[4]  = mk(5'b00100, 5'b00000, pk(10,12,5,0,42),  pk(20,30,6,32,55),  5'b00000, 5'b00100, 5'b00010, l1, 2);
        vecs[5]  = mk(5'b00100, 5'b00000, pk(10,12,63,0,42), pk(20,30,63,32,55), 5'b00000, 5'b00100, 5'b00010, l1, 2);
        vecs[6]  = mk(5'b00100, 5'b00000, pk(10,12,63,0,42), pk(20,30,0,32,55),  5'b00000, 5'b00100, 5'b00010, l1, 2);
        vecs[7]  = mk(5'b01000, 5'b00010, pk(10,12,63,0,42), pk(20,30,0,32,55),  5'b00000, 5'b00000, 5'b00000, 64'd0, 2);
        vecs[8]  = mk(5'b01000, 5'b00000, pk(10,12,63,0,42), pk(20,30,0,32,55),  5'b01000, 5'b00000, 5'b01000, l3, 3);
        vecs[9]  = mk(5'b00000, 5'b00001, pk(10,12,63,0,42), pk(20,30,0,32,55),  5'b00000, 5'b00000, 5'b01000, l3, 3);
        vecs[10] = mk(5'b00000, 5'b01000, pk(10,12,63,0,42), pk(20,30,0,32,55),  5'b00000, 5'b00000, 5'b00000, 64'd0, 3);
        vecs[11] = mk(5'b10001, 5'b00000, pk(40,12,63,0,42), pk(50,30,0,32,55),  5'b10000, 5'b00000, 5'b10000, l4, 4);
        vecs[12] = mk(5'b00001, 5'b00000, pk(40,12,63,0,42), pk(50,30,0,32,55),  5'b00000, 5'b00000, 5'b10000, l4, 4);
        vecs[13] = mk(5'b10000, 5'b00000, pk(40,12,63,0,10), pk(50,30,0,32,20),  5'b00000, 5'b00000, 5'b10000, l4, 4);
        vecs[14] = mk(5'b00001, 5'b10000, pk(40,12,63,0,10), pk(50,30,0,32,20),  5'b00000, 5'b00000, 5'b00000, 64'd0, 4);
        vecs[15] = mk(5'b00001, 5'b00000, pk(40,12,63,0,10), pk(50,30,0,32,20),  5'b00001, 5'b00000, 5'b00001, l5, 5);

        for (int i = 0; i < 16; i++) begin
            req = vecs[i].req; rel = vecs[i].rel; v1 = vecs[i].v1; v2 = vecs[i].v2;
            step();
            $display("vec %0d: req=%b rel=%b -> grant=%b reject=%b busy=%b lock_map=%h count=%0d",
                     i, vecs[i].req, vecs[i].rel, grant, reject, busy, lock_map, grant_count);
            chk($sformatf("vec%0d grant", i),    64'(grant),  64'(vecs[i].grant));
            chk($sformatf("vec%0d reject", i),   64'(reject), 64'(vecs[i].reject));
            chk($sformatf("vec%0d busy", i),     64'(busy),   64'(vecs[i].busy));
            chk($sformatf("vec%0d lock_map", i), lock_map,    vecs[i].lmap);
            chk($sformatf("vec%0d count", i),    64'(grant_count), 64'(vecs[i].gc));
            chk($sformatf("vec%0d timeout", i),  64'(timeout), 64'd0);
        end
        req = '0; rel = '0;

        // Round-robin: five disjoint windows requested together from rr_ptr=0.
        do_reset();
        v1 = pk(2, 10, 20, 30, 40);
        v2 = pk(5, 14, 24, 34, 44);
        req = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            step();
            $display("rr all: cycle %0d grant=%b count=%0d", c, grant, grant_count);
            chk($sformatf("rr all grant%0d", c), 64'(grant), 64'(5'b00001 << c));
        end
        req = '0;
        step();
        chk("rr all count", 64'(grant_count), 64'd5);
        chk("rr all busy",  64'(busy), 64'h1f);
        chk("rr all grant idle", 64'(grant), 64'd0);

        // Mid-operation reset clears everything at once.
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("mid reset: busy=%b lock_map=%h count=%0d", busy, lock_map, grant_count);
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset lock_map", lock_map, 64'd0);
        chk("mid reset count", 64'(grant_count), 64'd0);

        // rr_ptr=2 after granting worker 1: worker 3 beats worker 0.
        req = 5'b00010;
        step();
        chk("rr2 setup grant", 64'(grant), 64'b00010);
        req = 5'b01001;
        step();
        $display("rr2: grant=%b", grant);
        chk("rr2 first grant", 64'(grant), 64'b01000);
        step();
        $display("rr2: grant=%b", grant);
        chk("rr2 second grant", 64'(grant), 64'b00001);
        req = '0;
        step();
        chk("rr2 count", 64'(grant_count), 64'd3);
`else
        // Forced release after TIMEOUT=4 held cycles.
        v1 = pk(0, 10, 0, 0, 0);
        v2 = pk(0, 20, 0, 0, 0);
        req = 5'b00010;
        step();
        req = '0;
        $display("to: grant=%b busy=%b", grant, busy);
        chk("to grant", 64'(grant), 64'b00010);
        chk("to lock", lock_map, bm6(9, 10, 11, 19, 20, 21));
        for (int k = 1; k < 4; k++) begin
            step();
            $display("to: held cycle %0d busy=%b timeout=%b", k + 1, busy, timeout);
            chk($sformatf("to busy%0d", k), 64'(busy), 64'b00010);
            chk($sformatf("to pulse%0d", k), 64'(timeout), 64'd0);
        end
        step();
        $display("to: expired busy=%b timeout=%b lock_map=%h", busy, timeout, lock_map);
        chk("to fire", 64'(timeout), 64'b00010);
        chk("to busy clr", 64'(busy), 64'd0);
        chk("to lock clr", lock_map, 64'd0);
        rel = 5'b00010;
        step();
        rel = '0;
        $display("to: late release busy=%b timeout=%b", busy, timeout);
        chk("to late timeout", 64'(timeout), 64'd0);
        chk("to late busy", 64'(busy), 64'd0);
        chk("to late lock", lock_map, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
